psdsquare: RTL and testbench



---
 rtl/psdsquare_if.sv | 21 ++
 rtl/psdsquare.sv | 118 +++++++++++
 tb/tb_psdsquare.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/psdsquare_if.sv
// Start/busy/done handshake bundle for the psdsquare shift-add squarer.
// ROOT_CHECK_EN adds the xref/ok root-check signals.
interface psdsquare_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   xin;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] square;
`ifdef ROOT_CHECK_EN
  logic [2*WIDTH-1:0] xref;
  logic               ok;

  modport master (output start, xin, xref, input busy, done, square, ok);
  modport slave  (input start, xin, xref, output busy, done, square, ok);
`else
  modport master (output start, xin, input busy, done, square);
  modport slave  (input start, xin, output busy, done, square);
`endif
endinterface

// File: rtl/psdsquare.sv
// Sequential shift-add squarer: square = xin * xin, one multiplier bit per clock.
// Optional ROOT_CHECK_EN: ok flags whether xin == floor(sqrt(xref)).
module psdsquare #(
  parameter int WIDTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  psdsquare_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] square_q, square_d;
  logic               done_q, done_d;
`ifdef ROOT_CHECK_EN
  logic [2*WIDTH-1:0] xref_q, xref_d;
  logic [WIDTH-1:0]   root_q, root_d;
  logic               ok_q, ok_d;
  logic [2*WIDTH:0]   diff, twice_root;
  logic               ok_now;

  // One extra bit keeps xref - square and 2*root from wrapping.
  always_comb begin
    diff       = {1'b0, xref_q} - {1'b0, acc_q};
    twice_root = {{WIDTH{1'b0}}, root_q, 1'b0};
    ok_now     = (xref_q >= acc_q) && (diff <= twice_root);
  end
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    square_d = square_q;
    done_d   = 1'b0;
`ifdef ROOT_CHECK_EN
    xref_d   = xref_q;
    root_d   = root_q;
    ok_d     = ok_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.xin};
          mplier_d = bus.xin;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
`ifdef ROOT_CHECK_EN
          xref_d   = bus.xref;
          root_d   = bus.xin;
`endif
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        square_d = acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
`ifdef ROOT_CHECK_EN
        ok_d     = ok_now;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      square_q <= '0;
      done_q   <= 1'b0;
`ifdef ROOT_CHECK_EN
      xref_q   <= '0;
      root_q   <= '0;
      ok_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      square_q <= square_d;
      done_q   <= done_d;
`ifdef ROOT_CHECK_EN
      xref_q   <= xref_d;
      root_q   <= root_d;
      ok_q     <= ok_d;
`endif
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.square = square_q;
`ifdef ROOT_CHECK_EN
  assign bus.ok     = ok_q;
`endif
endmodule

// File: tb/tb_psdsquare.sv
// Scoreboard bench for psdsquare: driver pushes model results on accept, monitor checks on done.
module tb_psdsquare;
  localparam int W       = 16;
  localparam int LATENCY = W + 1;
  localparam int PERIOD  = W + 2;

  logic clock = 1'b0;
  logic reset;
  psdsquare_if #(.WIDTH(W)) bus ();

  psdsquare #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] sq;
    logic        ok;
    int unsigned acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  logic        prev_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_sq(input logic [15:0] x);
    logic [63:0] r;
    r = 64'(x);
    return 32'(r * r);
  endfunction

  // ok means x is the integer square root of xref.
  function automatic logic model_ok(input logic [15:0] x, input logic [31:0] xr);
    logic [63:0] r;
    r = 64'(x);
    return (r * r <= 64'(xr)) && ((r + 1) * (r + 1) > 64'(xr));
  endfunction

  task automatic push_exp(input logic [15:0] x, input logic [31:0] xr);
    sb.push_back('{sq: model_sq(x), ok: model_ok(x, xr), acc_cyc: cyc});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (bus.busy !== 1'b0) check("idle_timeout", 64'(bus.busy), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 0);
  endtask

  task automatic issue(input logic [15:0] x, input logic [31:0] xr);
    @(negedge clock);
    wait_idle();
    bus.start = 1'b1;
    bus.xin   = x;
`ifdef ROOT_CHECK_EN
    bus.xref  = xr;
`endif
    @(negedge clock);
    push_exp(x, xr);
    bus.start = 1'b0;
    bus.xin   = 16'($urandom);
    drain();
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (prev_done) check("done_one_cycle", 64'(bus.done), 0);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("square", 64'(bus.square), 64'(e.sq));
          check("latency", 64'(cyc - e.acc_cyc), 64'(LATENCY));
          check("busy_at_done", 64'(bus.busy), 0);
`ifdef ROOT_CHECK_EN
          check("ok", 64'(bus.ok), 64'(e.ok));
`endif
        end
      end
      prev_done <= (bus.done === 1'b1);
    end else begin
      prev_done <= 1'b0;
    end
  end

  initial begin
    int unsigned first;
    int n;
    logic [15:0] x;
    logic [31:0] xr;
    logic [63:0] base;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.xin   = '0;
`ifdef ROOT_CHECK_EN
    bus.xref  = '0;
`endif
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_square", 64'(bus.square), 0);
`ifdef ROOT_CHECK_EN
    check("rst_ok", 64'(bus.ok), 0);
`endif
    reset = 1'b0;

    issue(16'h0000, 32'h0);
    issue(16'hFFFF, 32'hFFFFFFFF);
    issue(16'h1234, 32'h014B5A90);
    issue(16'h0001, 32'h00000001);

    // Held start: second operand changes mid-run and must wait for DONE.
    @(negedge clock);
    wait_idle();
    bus.start = 1'b1;
    bus.xin   = 16'h0003;
    @(negedge clock);
    push_exp(16'h0003, 32'h0);
    first = cyc;
    repeat (5) @(negedge clock);
    bus.xin = 16'h0002;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.busy !== 1'b0 && n < 40);
    if (bus.busy !== 1'b0) check("b2b_timeout", 64'(bus.busy), 0);
    @(negedge clock);
    check("b2b_accept_busy", 64'(bus.busy), 1);
    check("b2b_period", 64'(cyc - first), 64'(PERIOD));
    push_exp(16'h0002, 32'h0);
    bus.start = 1'b0;
    drain();

    // Asynchronous reset mid-run, between clock edges.
    @(negedge clock);
    wait_idle();
    bus.start = 1'b1;
    bus.xin   = 16'hFFFF;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (8) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_busy", 64'(bus.busy), 0);
    check("async_done", 64'(bus.done), 0);
    check("async_square", 64'(bus.square), 0);
`ifdef ROOT_CHECK_EN
    check("async_ok", 64'(bus.ok), 0);
`endif
    @(negedge clock);
    reset = 1'b0;
    issue(16'h0010, 32'h0);

`ifdef ROOT_CHECK_EN
    issue(16'h0100, 32'h00010000);
    issue(16'h0100, 32'h00010200);
    issue(16'h0100, 32'h00010201);
    issue(16'h0100, 32'h0000FFFF);
    issue(16'hFFFF, 32'hFFFFFFFF);
`endif

    for (int i = 0; i < 20; i++) begin
      x    = 16'($urandom_range(0, 65535));
      base = 64'(x) * 64'(x);
      case ($urandom_range(0, 3))
        0:       xr = 32'(base);
        1:       xr = 32'(base + 2 * 64'(x));
        2:       xr = 32'(base + 2 * 64'(x) + 1);
        default: xr = 32'(base - 1);
      endcase
      issue(x, xr);
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
